fft4_stream: RTL and testbench

FFT4_STREAM -- requirements
Module: fft4_stream

---
 rtl/fft4_stream.sv | 155 +++++++++++++++
 tb/tb_fft4_stream.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft4_stream.sv
// Streaming 4-point FFT/IFFT: collects four complex samples, computes all bins in one cycle,
// then streams them out in bin order. Define FFT4_STREAM_SCALE_EN to divide every bin by 4.
module fft4_stream #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         en,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [DATA_WIDTH-1:0] in_real,
   input  logic signed [DATA_WIDTH-1:0] in_imag,
   input  logic                         inverse,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [DATA_WIDTH+1:0] out_real,
   output logic signed [DATA_WIDTH+1:0] out_imag,
   output logic [1:0]                   out_index,
   output logic                         out_last
);

   localparam int OW = DATA_WIDTH + 2;

   typedef enum logic [1:0] {COLLECT, COMPUTE, OUTPUT} state_t;

   state_t                       r_state;
   logic [1:0]                   r_n;
   logic [1:0]                   r_k;
   logic                         r_inv;
   logic                         r_last;
   logic signed [DATA_WIDTH-1:0] r_xr [0:3];
   logic signed [DATA_WIDTH-1:0] r_xi [0:3];
   logic signed [OW-1:0]         r_br [0:3];
   logic signed [OW-1:0]         r_bi [0:3];
   logic signed [OW-1:0]         r_out_real;
   logic signed [OW-1:0]         r_out_imag;

   logic signed [OW-1:0] w_xr [0:3];
   logic signed [OW-1:0] w_xi [0:3];
   logic signed [OW-1:0] w_bin_r [0:3];
   logic signed [OW-1:0] w_bin_i [0:3];
   logic signed [OW-1:0] w_sc_r [0:3];
   logic signed [OW-1:0] w_sc_i [0:3];
   logic signed [OW-1:0] w_sum_ac_r, w_sum_ac_i, w_sum_bd_r, w_sum_bd_i;
   logic signed [OW-1:0] w_dif_ac_r, w_dif_ac_i, w_dif_bd_r, w_dif_bd_i;
   logic signed [OW-1:0] w_rot_r, w_rot_i;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_ext
         assign w_xr[gi] = {{2{r_xr[gi][DATA_WIDTH-1]}}, r_xr[gi]};
         assign w_xi[gi] = {{2{r_xi[gi][DATA_WIDTH-1]}}, r_xi[gi]};
      end
   endgenerate

   // Radix-2 split: a,c and b,d pairs, then the +/-j rotation of (b-d).
   assign w_sum_ac_r = w_xr[0] + w_xr[2];
   assign w_sum_ac_i = w_xi[0] + w_xi[2];
   assign w_sum_bd_r = w_xr[1] + w_xr[3];
   assign w_sum_bd_i = w_xi[1] + w_xi[3];
   assign w_dif_ac_r = w_xr[0] - w_xr[2];
   assign w_dif_ac_i = w_xi[0] - w_xi[2];
   assign w_dif_bd_r = w_xr[1] - w_xr[3];
   assign w_dif_bd_i = w_xi[1] - w_xi[3];

   // Forward uses -j(b-d) for X1; inverse uses +j(b-d).
   assign w_rot_r = r_inv ? -w_dif_bd_i :  w_dif_bd_i;
   assign w_rot_i = r_inv ?  w_dif_bd_r : -w_dif_bd_r;

   assign w_bin_r[0] = w_sum_ac_r + w_sum_bd_r;
   assign w_bin_i[0] = w_sum_ac_i + w_sum_bd_i;
   assign w_bin_r[1] = w_dif_ac_r + w_rot_r;
   assign w_bin_i[1] = w_dif_ac_i + w_rot_i;
   assign w_bin_r[2] = w_sum_ac_r - w_sum_bd_r;
   assign w_bin_i[2] = w_sum_ac_i - w_sum_bd_i;
   assign w_bin_r[3] = w_dif_ac_r - w_rot_r;
   assign w_bin_i[3] = w_dif_ac_i - w_rot_i;

   generate
      for (gi = 0; gi < 4; gi++) begin : g_scale
`ifdef FFT4_STREAM_SCALE_EN
         assign w_sc_r[gi] = w_bin_r[gi] >>> 2;
         assign w_sc_i[gi] = w_bin_i[gi] >>> 2;
`else
         assign w_sc_r[gi] = w_bin_r[gi];
         assign w_sc_i[gi] = w_bin_i[gi];
`endif
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= COLLECT;
         r_n        <= 2'd0;
         r_k        <= 2'd0;
         r_inv      <= 1'b0;
         r_last     <= 1'b0;
         r_out_real <= '0;
         r_out_imag <= '0;
         for (int i = 0; i < 4; i++) begin
            r_xr[i] <= '0;
            r_xi[i] <= '0;
            r_br[i] <= '0;
            r_bi[i] <= '0;
         end
      end else if (en) begin
         case (r_state)
            COLLECT: begin
               if (in_valid) begin
                  r_xr[r_n] <= in_real;
                  r_xi[r_n] <= in_imag;
                  if (r_n == 2'd0) r_inv <= inverse;
                  r_n <= r_n + 2'd1;
                  if (r_n == 2'd3) r_state <= COMPUTE;
               end
            end
            COMPUTE: begin
               for (int i = 0; i < 4; i++) begin
                  r_br[i] <= w_sc_r[i];
                  r_bi[i] <= w_sc_i[i];
               end
               r_out_real <= w_sc_r[0];
               r_out_imag <= w_sc_i[0];
               r_k        <= 2'd0;
               r_last     <= 1'b0;
               r_state    <= OUTPUT;
            end
            OUTPUT: begin
               if (out_ready) begin
                  if (r_k == 2'd3) begin
                     r_k     <= 2'd0;
                     r_last  <= 1'b0;
                     r_state <= COLLECT;
                  end else begin
                     r_k        <= r_k + 2'd1;
                     r_out_real <= r_br[r_k + 2'd1];
                     r_out_imag <= r_bi[r_k + 2'd1];
                     r_last     <= (r_k == 2'd2);
                  end
               end
            end
            default: r_state <= COLLECT;
         endcase
      end
   end

   // Handshake flags are gated by en and rst_n so they drop immediately.
   assign in_ready  = rst_n & en & (r_state == COLLECT);
   assign out_valid = rst_n & en & (r_state == OUTPUT);
   assign out_real  = r_out_real;
   assign out_imag  = r_out_imag;
   assign out_index = r_k;
   assign out_last  = r_last;

endmodule

// File: tb/tb_fft4_stream.sv
// Directed bench for fft4_stream: a DFT reference model fills a scoreboard per frame and a
// negedge monitor pops and compares every accepted output bin.
`define CHK(tag, obs, exp) begin tests++; assert ((obs) === (exp)) else begin fails++; $error("FAIL %s observed=%0d expected=%0d", tag, (obs), (exp)); end end

module tb_fft4_stream;
   localparam int DW = 8;

   typedef struct {
      logic signed [DW+1:0] re;
      logic signed [DW+1:0] im;
      logic [1:0]           idx;
      logic                 last;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b1;
   logic                 en = 1'b1;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic signed [DW-1:0] in_real = '0;
   logic signed [DW-1:0] in_imag = '0;
   logic                 inverse = 1'b0;
   logic                 out_valid;
   logic                 out_ready = 1'b1;
   logic signed [DW+1:0] out_real;
   logic signed [DW+1:0] out_imag;
   logic [1:0]           out_index;
   logic                 out_last;

   int   tests = 0;
   int   fails = 0;
   exp_t exp_q[$];
   exp_t mon_e;
   int   fr_r [4];
   int   fr_i [4];

   fft4_stream #(.DATA_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_real(in_real), .in_imag(in_imag), .inverse(inverse),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_real(out_real), .out_imag(out_imag),
      .out_index(out_index), .out_last(out_last)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   // Scoreboard monitor: a bin is consumed at the next rising edge when valid&ready.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL unexpected_bin observed index=%0d", out_index);
         end else begin
            mon_e = exp_q.pop_front();
            tests++;
            if (out_real !== mon_e.re) begin
               fails++;
               $error("FAIL bin_re observed=%0d expected=%0d", out_real, mon_e.re);
            end
            tests++;
            if (out_imag !== mon_e.im) begin
               fails++;
               $error("FAIL bin_im observed=%0d expected=%0d", out_imag, mon_e.im);
            end
            tests++;
            if (out_index !== mon_e.idx) begin
               fails++;
               $error("FAIL bin_idx observed=%0d expected=%0d", out_index, mon_e.idx);
            end
            tests++;
            if (out_last !== mon_e.last) begin
               fails++;
               $error("FAIL bin_last observed=%0d expected=%0d", out_last, mon_e.last);
            end
            $display("[TB] bin k=%0d re=%0d im=%0d last=%0d", out_index, out_real, out_imag, out_last);
         end
      end
   end

   // Direct DFT with twiddle table e^(-+j*pi*m/2), independent of the butterfly form.
   task automatic push_frame(input bit inv);
      exp_t e;
      int sr, si, m, c, s;
      for (int k = 0; k < 4; k++) begin
         sr = 0;
         si = 0;
         for (int n = 0; n < 4; n++) begin
            m = (k * n) % 4;
            case (m)
               0: begin c = 1;  s = 0;  end
               1: begin c = 0;  s = -1; end
               2: begin c = -1; s = 0;  end
               default: begin c = 0; s = 1; end
            endcase
            if (inv) s = -s;
            sr += fr_r[n] * c - fr_i[n] * s;
            si += fr_r[n] * s + fr_i[n] * c;
         end
`ifdef FFT4_STREAM_SCALE_EN
         sr = sr >>> 2;
         si = si >>> 2;
`endif
         e.re   = 10'(sr);
         e.im   = 10'(si);
         e.idx  = 2'(k);
         e.last = (k == 3);
         exp_q.push_back(e);
      end
   endtask

   task automatic send(input int re, input int im, input bit inv, input int gap, input bit pause);
      bit ok;
      in_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      if (pause) begin
         en = 1'b0;
         @(posedge clk); #1;
         `CHK("pause_in_ready", in_ready, 1'b0)
         `CHK("pause_out_valid", out_valid, 1'b0)
         en = 1'b1;
      end
      in_real  = DW'(re);
      in_imag  = DW'(im);
      inverse  = inv;
      in_valid = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 100 && !ok; t++) begin
         @(negedge clk);
         if (in_ready === 1'b1) begin
            @(posedge clk); #1;
            ok = 1'b1;
         end
      end
      in_valid = 1'b0;
      `CHK("send_timeout", ok, 1'b1)
   endtask

   task automatic send_frame(input bit inv, input int gap, input bit pause);
      push_frame(inv);
      for (int n = 0; n < 4; n++)
         send(fr_r[n], fr_i[n], (n == 0) ? inv : ~inv, gap, pause);
      `CHK("lat_compute_valid", out_valid, 1'b0)
      `CHK("lat_compute_ready", in_ready, 1'b0)
      @(posedge clk); #1;
      `CHK("lat_out_valid", out_valid, 1'b1)
      `CHK("lat_out_index", out_index, 2'd0)
   endtask

   task automatic drain();
      bit ok;
      ok = 1'b0;
      for (int t = 0; t < 300; t++) begin
         if (exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      `CHK("drain_timeout", ok, 1'b1)
      `CHK("post_frame_in_ready", in_ready, 1'b1)
      `CHK("post_frame_out_valid", out_valid, 1'b0)
      `CHK("post_frame_out_last", out_last, 1'b0)
   endtask

   task automatic set_frame(input int r0, input int r1, input int r2, input int r3,
                            input int i0, input int i1, input int i2, input int i3);
      fr_r[0] = r0; fr_r[1] = r1; fr_r[2] = r2; fr_r[3] = r3;
      fr_i[0] = i0; fr_i[1] = i1; fr_i[2] = i2; fr_i[3] = i3;
   endtask

   initial begin
      exp_t e;
      // Reset values
      #2 rst_n = 1'b0;
      #3;
      `CHK("rst_in_ready", in_ready, 1'b0)
      `CHK("rst_out_valid", out_valid, 1'b0)
      `CHK("rst_out_real", out_real, 10'sd0)
      `CHK("rst_out_imag", out_imag, 10'sd0)
      `CHK("rst_out_index", out_index, 2'd0)
      `CHK("rst_out_last", out_last, 1'b0)
      @(negedge clk); rst_n = 1'b1;
      #1;
      `CHK("rel_in_ready", in_ready, 1'b1)
      @(posedge clk); #1;

      // Forward frame, real inputs
      set_frame(1, 2, -1, 3, 0, 0, 0, 0);
      send_frame(1'b0, 0, 1'b0);
      drain();

      // Inverse captured on x[0] only
      send_frame(1'b1, 0, 1'b0);
      drain();

      // Extreme negative inputs
      set_frame(-128, -128, -128, -128, -128, -128, -128, -128);
      send_frame(1'b0, 0, 1'b0);
      drain();

      // Backpressure on bin 1
      set_frame(7, -3, 12, 5, -9, 4, 0, -6);
      out_ready = 1'b0;
      send_frame(1'b0, 0, 1'b0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      e = exp_q[0];
      repeat (3) begin
         @(posedge clk); #1;
         `CHK("stall_re", out_real, e.re)
         `CHK("stall_im", out_imag, e.im)
         `CHK("stall_idx", out_index, 2'd1)
         `CHK("stall_in_ready", in_ready, 1'b0)
         `CHK("stall_out_valid", out_valid, 1'b1)
      end
      out_ready = 1'b1;
      drain();

      // Gaps and en pauses between samples, then reset after two samples
      send(100, -50, 1'b0, 2, 1'b1);
      send(-7, 33, 1'b1, 1, 1'b1);
      rst_n = 1'b0;
      #2;
      `CHK("partial_rst_ready", in_ready, 1'b0)
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      set_frame(-20, 35, 64, -100, 17, -1, 90, 3);
      send_frame(1'b1, 2, 1'b1);
      // en dropped mid-output must not lose or repeat a bin
      en = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      `CHK("en_low_out_valid", out_valid, 1'b0)
      en = 1'b1;
      drain();

      // Reset in the middle of output discards the frame
      set_frame(3, 1, 4, 1, 5, 9, 2, 6);
      out_ready = 1'b0;
      send_frame(1'b0, 0, 1'b0);
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      `CHK("midout_rst_valid", out_valid, 1'b0)
      `CHK("midout_rst_real", out_real, 10'sd0)
      `CHK("midout_rst_last", out_last, 1'b0)
      @(negedge clk); rst_n = 1'b1;
      out_ready = 1'b1;
      #1;
      `CHK("midout_rel_ready", in_ready, 1'b1)
      @(posedge clk); #1;

      // Random frames, alternating direction
      for (int f = 0; f < 4; f++) begin
         for (int n = 0; n < 4; n++) begin
            fr_r[n] = int'($urandom_range(0, 255)) - 128;
            fr_i[n] = int'($urandom_range(0, 255)) - 128;
         end
         send_frame(f[0], f % 2, 1'b0);
         drain();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
